// File: rtl/sha256_msg_feeder_pkg.sv
// Shared constants, state encoding and padding helper for the SHA-256 message feeder.
package sha256_msg_feeder_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned IDX_W       = 5;

  localparam logic [WORD_W-1:0] PAD_WORD  = 32'h8000_0000;
  localparam logic [255:0]      SHA256_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_PAD   = 3'd1,
    ST_LEN   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Keep the valid leading bytes of the final word, place 0x80 right after them, zero the rest.
  function automatic logic [WORD_W-1:0] pad_last_word(input logic [WORD_W-1:0] data,
                                                      input logic [2:0]        nbytes);
    logic [WORD_W-1:0] w;
    w = data;
    case (nbytes)
      3'd0:    w = PAD_WORD;
      3'd1:    w = {data[31:24], 24'h80_0000};
      3'd2:    w = {data[31:16], 16'h8000};
      3'd3:    w = {data[31:8], 8'h80};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha256_msg_feeder_fsm.sv
// Control for the feeder: block word index, padding/final/first flags and the core/consumer handshakes.
module sha256_msg_feeder_fsm
  import sha256_msg_feeder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       msg_valid_i,
  input  logic       msg_last_i,
  input  logic [2:0] msg_bytes_i,
  input  logic       core_digest_valid_i,
  input  logic       hash_ready_i,
  output logic       msg_ready_o,
  output logic       core_init_o,
  output logic       core_first_block_o,
  output logic       hash_valid_o,
  output logic [3:0] wr_idx_o,
  output logic       pad_done_o,
  output logic       fill_we_c_o,
  output logic       pad_we_c_o,
  output logic       len_we_c_o,
  output logic       chain_we_c_o,
  output logic       len_clr_c_o
);

  state_e           state_q, state_d;
  state_e           resume_q, resume_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;
  logic             pad_done_q, pad_done_d;
  logic             final_q, final_d;
  logic             msg_ready_q, core_init_q, core_first_q, hash_valid_q;
  logic             xfer;

  assign xfer = msg_valid_i & msg_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FILL;
      resume_q     <= ST_FILL;
      idx_q        <= '0;
      first_q      <= 1'b1;
      pad_done_q   <= 1'b0;
      final_q      <= 1'b0;
      msg_ready_q  <= 1'b0;
      core_init_q  <= 1'b0;
      core_first_q <= 1'b0;
      hash_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      idx_q        <= idx_d;
      first_q      <= first_d;
      pad_done_q   <= pad_done_d;
      final_q      <= final_d;
      // Handshake outputs are registered copies of the state being entered.
      msg_ready_q  <= (state_d == ST_FILL);
      core_init_q  <= (state_d == ST_ISSUE);
      hash_valid_q <= (state_d == ST_DONE);
      if (state_d == ST_ISSUE) core_first_q <= first_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    resume_d     = resume_q;
    idx_d        = idx_q;
    first_d      = first_q;
    pad_done_d   = pad_done_q;
    final_d      = final_q;
    fill_we_c_o  = 1'b0;
    pad_we_c_o   = 1'b0;
    len_we_c_o   = 1'b0;
    chain_we_c_o = 1'b0;
    len_clr_c_o  = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (xfer) begin
          fill_we_c_o = 1'b1;
          idx_d       = idx_q + IDX_W'(1);
          if (msg_last_i) begin
            pad_done_d = (msg_bytes_i < 3'd4);
            state_d    = ST_PAD;
          end else if (idx_q == IDX_W'(BLOCK_WORDS - 1)) begin
            resume_d = ST_FILL;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_PAD: begin
        // A full block ships first; the length words must land in 14/15 of the block being built.
        if (idx_q == IDX_W'(BLOCK_WORDS)) begin
          resume_d = ST_PAD;
          state_d  = ST_ISSUE;
        end else if ((idx_q == IDX_W'(BLOCK_WORDS - 2)) && pad_done_q) begin
          state_d = ST_LEN;
        end else begin
          pad_we_c_o = 1'b1;
          pad_done_d = 1'b1;
          idx_d      = idx_q + IDX_W'(1);
        end
      end
      ST_LEN: begin
        len_we_c_o = 1'b1;
        final_d    = 1'b1;
        idx_d      = IDX_W'(BLOCK_WORDS);
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: begin
        first_d = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_digest_valid_i) begin
          chain_we_c_o = 1'b1;
          idx_d        = '0;
          state_d      = final_q ? ST_DONE : resume_q;
        end
      end
      ST_DONE: begin
        if (hash_ready_i) begin
          len_clr_c_o = 1'b1;
          pad_done_d  = 1'b0;
          final_d     = 1'b0;
          first_d     = 1'b1;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign msg_ready_o        = msg_ready_q;
  assign core_init_o        = core_init_q;
  assign core_first_block_o = core_first_q;
  assign hash_valid_o       = hash_valid_q;
  assign wr_idx_o           = idx_q[3:0];
  assign pad_done_o         = pad_done_q;

endmodule

// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: pads a 32-bit word stream into 512-bit blocks, chains digests through the core.
module sha256_msg_feeder
  import sha256_msg_feeder_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  input  logic         msg_last,
  input  logic [2:0]   msg_bytes,
  output logic         core_init,
  output logic [511:0] core_block,
  output logic         core_first_block,
  output logic [255:0] core_prev_digest,
  input  logic         core_digest_valid,
  input  logic [255:0] core_digest,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic [255:0] hash
);

  logic [WORD_W-1:0] blk_q [BLOCK_WORDS];
  logic [LEN_W-1:0]  len_q;
  logic [255:0]      chain_q;
  logic [63:0]       len64;
  logic [3:0]        wr_idx;
  logic              pad_done;
  logic              fill_we, pad_we, len_we, chain_we, len_clr;

  sha256_msg_feeder_fsm u_fsm (
    .clk                 (clk),
    .reset               (reset),
    .msg_valid_i         (msg_valid),
    .msg_last_i          (msg_last),
    .msg_bytes_i         (msg_bytes),
    .core_digest_valid_i (core_digest_valid),
    .hash_ready_i        (hash_ready),
    .msg_ready_o         (msg_ready),
    .core_init_o         (core_init),
    .core_first_block_o  (core_first_block),
    .hash_valid_o        (hash_valid),
    .wr_idx_o            (wr_idx),
    .pad_done_o          (pad_done),
    .fill_we_c_o         (fill_we),
    .pad_we_c_o          (pad_we),
    .len_we_c_o          (len_we),
    .chain_we_c_o        (chain_we),
    .len_clr_c_o         (len_clr)
  );

  assign len64 = 64'(len_q);

  // Block word registers; untouched during ISSUE/WAIT so the core sees a stable block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BLOCK_WORDS; i++) blk_q[i] <= '0;
    end else begin
      if (fill_we) blk_q[wr_idx] <= msg_last ? pad_last_word(msg_data, msg_bytes) : msg_data;
      if (pad_we)  blk_q[wr_idx] <= pad_done ? '0 : PAD_WORD;
      if (len_we) begin
        blk_q[BLOCK_WORDS-2] <= len64[63:32];
        blk_q[BLOCK_WORDS-1] <= len64[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q <= '0;
    end else if (len_clr) begin
      len_q <= '0;
    end else if (fill_we) begin
      len_q <= len_q + (msg_last ? LEN_W'({msg_bytes, 3'b000}) : LEN_W'(WORD_W));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else if (chain_we) begin
      chain_q <= core_digest;
    end
  end

  always_comb begin
    core_block = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) core_block[511-32*i -: 32] = blk_q[i];
  end

  assign core_prev_digest = chain_q;
  assign hash             = chain_q;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: behavioural SHA-256 core responder plus a byte-level padding/hash reference.
module tb_sha256_msg_feeder;

  typedef logic [7:0]   bq_t   [$];
  typedef logic [511:0] blkq_t [$];

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk, reset;
  logic         msg_valid, msg_ready, msg_last;
  logic [31:0]  msg_data;
  logic [2:0]   msg_bytes;
  logic         core_init, core_first_block, core_digest_valid;
  logic [511:0] core_block;
  logic [255:0] core_prev_digest, core_digest;
  logic         hash_valid, hash_ready;
  logic [255:0] hash;

  int checks = 0;
  int errors = 0;

  sha256_msg_feeder #(.LEN_W(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .msg_valid         (msg_valid),
    .msg_ready         (msg_ready),
    .msg_data          (msg_data),
    .msg_last          (msg_last),
    .msg_bytes         (msg_bytes),
    .core_init         (core_init),
    .core_block        (core_block),
    .core_first_block  (core_first_block),
    .core_prev_digest  (core_prev_digest),
    .core_digest_valid (core_digest_valid),
    .core_digest       (core_digest),
    .hash_valid        (hash_valid),
    .hash_ready        (hash_ready),
    .hash              (hash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Byte-level FIPS 180-4 padding: append 0x80, zero-fill to 56 mod 64, append 64-bit bit length.
  function automatic void pad_ref(input bq_t m, output blkq_t blks);
    bq_t          p;
    logic [63:0]  bitlen;
    logic [511:0] blk;
    p = m;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bitlen = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    blks.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      blks.push_back(blk);
    end
  endfunction

  // Behavioural core: compresses the presented block after a random latency, logs what it was given.
  blkq_t              blk_log;
  logic               first_log [$];
  logic [255:0]       prev_log  [$];
  logic               core_busy;
  int                 core_cnt;
  logic [255:0]       core_res;
  logic [511:0]       core_snap;
  int                 stab_err = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_busy         <= 1'b0;
      core_cnt          <= 0;
      core_digest_valid <= 1'b0;
      core_digest       <= '0;
    end else begin
      core_digest_valid <= 1'b0;
      if (core_init) begin
        core_busy <= 1'b1;
        core_cnt  <= $urandom_range(1, 5);
        core_snap <= core_block;
        core_res  <= sha_compress(core_first_block ? IV : core_prev_digest, core_block);
        blk_log.push_back(core_block);
        first_log.push_back(core_first_block);
        prev_log.push_back(core_prev_digest);
      end else if (core_busy) begin
        if (core_block !== core_snap) stab_err <= stab_err + 1;
        if (core_cnt == 0) begin
          core_busy         <= 1'b0;
          core_digest_valid <= 1'b1;
          core_digest       <= core_res;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  task automatic clear_logs();
    blk_log.delete();
    first_log.delete();
    prev_log.delete();
  endtask

  task automatic send_msg(input bq_t m, input int gap_max, output bit to);
    int          n, nb, budget;
    logic [31:0] w;
    to = 1'b0;
    n  = (m.size() + 3) / 4;
    if (n == 0) n = 1;
    for (int k = 0; k < n; k++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(negedge clk);
          msg_valid = 1'b0; msg_data = $urandom; msg_last = 1'($urandom); msg_bytes = 3'($urandom);
        end
      end
      nb = m.size() - 4 * k;
      if (nb > 4) nb = 4;
      w = $urandom;
      for (int j = 0; j < nb; j++) w[31-8*j -: 8] = m[4*k+j];
      @(negedge clk);
      msg_valid = 1'b1;
      msg_data  = w;
      msg_last  = (k == n - 1);
      msg_bytes = (k == n - 1) ? 3'(nb) : 3'($urandom_range(0, 4));
      budget = 0;
      while (msg_ready !== 1'b1 && budget < 1000) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 1000) begin
        to = 1'b1;
        msg_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic wait_hash(output bit to);
    int budget = 0;
    while (hash_valid !== 1'b1 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    to = (budget >= 2000);
  endtask

  task automatic accept_hash();
    hash_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hash_ready = 1'b0;
  endtask

  task automatic run_msg(input bq_t m, input int gap_max, output logic [255:0] h, output bit to);
    bit t1, t2;
    clear_logs();
    send_msg(m, gap_max, t1);
    t2 = 1'b1;
    if (!t1) wait_hash(t2);
    to = t1 | t2;
    h  = hash;
    if (!to) accept_hash();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL reset_msg_ready got %0b want 0", msg_ready); end
    checks++; if (core_init !== 1'b0 || core_first_block !== 1'b0) begin errors++; $display("FAIL reset_core_ctl got init=%0b first=%0b want 0 0", core_init, core_first_block); end
    checks++; if (core_block !== '0) begin errors++; $display("FAIL reset_core_block got %h want 0", core_block); end
    checks++; if (hash_valid !== 1'b0 || hash !== '0 || core_prev_digest !== '0) begin errors++; $display("FAIL reset_hash got v=%0b hash=%h prev=%h want 0", hash_valid, hash, core_prev_digest); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b want 1", msg_ready); end
  endtask

  task automatic test_abc();
    bq_t m; logic [255:0] h; bit to;
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 0, h, to);
    checks++; if (to) begin errors++; $display("FAIL abc_timeout got timeout want hash"); end
    checks++; if (h !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin errors++; $display("FAIL abc_hash got %h", h); end
    checks++; if (blk_log.size() != 1) begin errors++; $display("FAIL abc_blocks got %0d want 1", blk_log.size()); end
    else begin
      checks++; if (blk_log[0][511:480] !== 32'h61626380 || blk_log[0][31:0] !== 32'h18) begin errors++; $display("FAIL abc_block got w0=%h w15=%h want 61626380 00000018", blk_log[0][511:480], blk_log[0][31:0]); end
      checks++; if (first_log[0] !== 1'b1) begin errors++; $display("FAIL abc_first got %0b want 1", first_log[0]); end
    end
  endtask

  task automatic test_empty();
    bq_t m; logic [255:0] h; bit to;
    m.delete();
    run_msg(m, 0, h, to);
    checks++; if (to) begin errors++; $display("FAIL empty_timeout got timeout want hash"); end
    checks++; if (h !== 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855) begin errors++; $display("FAIL empty_hash got %h", h); end
    checks++; if (blk_log.size() != 1) begin errors++; $display("FAIL empty_blocks got %0d want 1", blk_log.size()); end
    else begin
      checks++; if (blk_log[0] !== {32'h8000_0000, 480'b0}) begin errors++; $display("FAIL empty_block got %h", blk_log[0]); end
    end
  endtask

  task automatic test_55_56();
    bq_t m; blkq_t exp; logic [255:0] h, chain; bit to;
    for (int len = 55; len <= 56; len++) begin
      m.delete();
      repeat (len) m.push_back(8'h61);
      run_msg(m, 1, h, to);
      pad_ref(m, exp);
      checks++; if (to) begin errors++; $display("FAIL a%0d_timeout got timeout want hash", len); end
      checks++; if (blk_log.size() != ((len == 55) ? 1 : 2)) begin errors++; $display("FAIL a%0d_init_count got %0d want %0d", len, blk_log.size(), (len == 55) ? 1 : 2); end
      chain = IV;
      foreach (exp[i]) chain = sha_compress(chain, exp[i]);
      checks++; if (h !== chain) begin errors++; $display("FAIL a%0d_hash got %h want %h", len, h, chain); end
      if (len == 56 && blk_log.size() == 2) begin
        checks++; if (blk_log[1][511:480] !== 32'h0 || blk_log[1][63:0] !== 64'h1c0) begin errors++; $display("FAIL a56_blk2 got w0=%h len=%h want 0 1c0", blk_log[1][511:480], blk_log[1][63:0]); end
        checks++; if (first_log[0] !== 1'b1 || first_log[1] !== 1'b0) begin errors++; $display("FAIL a56_first got %0b%0b want 10", first_log[0], first_log[1]); end
        checks++; if (prev_log[1] !== sha_compress(IV, exp[0])) begin errors++; $display("FAIL a56_prev got %h want %h", prev_log[1], sha_compress(IV, exp[0])); end
      end
    end
  endtask

  task automatic test_full_block();
    bq_t m; logic [255:0] h, d0; bit to;
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    run_msg(m, 0, h, to);
    checks++; if (to) begin errors++; $display("FAIL full_timeout got timeout want hash"); end
    checks++; if (blk_log.size() != 2) begin errors++; $display("FAIL full_init_count got %0d want 2", blk_log.size()); end
    else begin
      d0 = sha_compress(IV, blk_log[0]);
      checks++; if (blk_log[1] !== {32'h8000_0000, 416'b0, 64'h200}) begin errors++; $display("FAIL full_blk2 got %h", blk_log[1]); end
      checks++; if (first_log[0] !== 1'b1 || first_log[1] !== 1'b0) begin errors++; $display("FAIL full_first got %0b%0b want 10", first_log[0], first_log[1]); end
      checks++; if (prev_log[1] !== d0) begin errors++; $display("FAIL full_prev got %h want %h", prev_log[1], d0); end
      checks++; if (h !== sha_compress(d0, {32'h8000_0000, 416'b0, 64'h200})) begin errors++; $display("FAIL full_hash got %h", h); end
    end
  endtask

  task automatic test_random_gaps();
    bq_t m; blkq_t exp; logic [255:0] h0, chain; bit t1, t2;
    for (int it = 0; it < 6; it++) begin
      m.delete();
      repeat ($urandom_range(0, 140)) m.push_back(8'($urandom));
      pad_ref(m, exp);
      clear_logs();
      send_msg(m, 3, t1);
      t2 = 1'b1;
      if (!t1) wait_hash(t2);
      checks++; if (t1 | t2) begin errors++; $display("FAIL rnd%0d_timeout len=%0d got timeout want hash", it, m.size()); end
      h0 = hash;
      repeat (20) begin
        @(negedge clk);
        checks++; if (msg_ready !== 1'b0 || hash_valid !== 1'b1) begin errors++; $display("FAIL rnd%0d_hold got ready=%0b valid=%0b want 0 1", it, msg_ready, hash_valid); end
        checks++; if (hash !== h0) begin errors++; $display("FAIL rnd%0d_stable got %h want %h", it, hash, h0); end
      end
      accept_hash();
      chain = IV;
      checks++; if (blk_log.size() != exp.size()) begin errors++; $display("FAIL rnd%0d_blocks got %0d want %0d", it, blk_log.size(), exp.size()); end
      else begin
        foreach (exp[i]) begin
          checks++; if (blk_log[i] !== exp[i]) begin errors++; $display("FAIL rnd%0d_blk%0d got %h want %h", it, i, blk_log[i], exp[i]); end
          checks++; if (first_log[i] !== (i == 0)) begin errors++; $display("FAIL rnd%0d_first%0d got %0b want %0b", it, i, first_log[i], i == 0); end
          if (i > 0) begin
            checks++; if (prev_log[i] !== chain) begin errors++; $display("FAIL rnd%0d_prev%0d got %h want %h", it, i, prev_log[i], chain); end
          end
          chain = sha_compress(chain, exp[i]);
        end
      end
      checks++; if (h0 !== chain) begin errors++; $display("FAIL rnd%0d_hash got %h want %h", it, h0, chain); end
    end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL block_stability got %0d changes want 0", stab_err); end
  endtask

  task automatic test_reset_wait();
    bq_t m; logic [255:0] h; bit to; int budget;
    for (int i = 0; i < 60; i++) m.push_back(8'($urandom));
    clear_logs();
    send_msg(m, 0, to);
    budget = 0;
    while (core_init !== 1'b1 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    checks++; if (to || budget >= 500) begin errors++; $display("FAIL rstwait_issue got no core_init want one"); end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (msg_ready !== 1'b0 || core_init !== 1'b0 || hash_valid !== 1'b0 || core_first_block !== 1'b0) begin errors++; $display("FAIL rstwait_ctl got ready=%0b init=%0b valid=%0b first=%0b want 0", msg_ready, core_init, hash_valid, core_first_block); end
    checks++; if (core_block !== '0 || core_prev_digest !== '0 || hash !== '0) begin errors++; $display("FAIL rstwait_data got nonzero block/digest want 0"); end
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    repeat (10) @(negedge clk);
    checks++; if (blk_log.size() != 0) begin errors++; $display("FAIL rstwait_idle got %0d core_init want 0", blk_log.size()); end
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 2, h, to);
    checks++; if (to || h !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin errors++; $display("FAIL rstwait_abc got %h to=%0b", h, to); end
    checks++; if (blk_log.size() != 1 || first_log[0] !== 1'b1) begin errors++; $display("FAIL rstwait_abc_blocks got %0d want 1 with first", blk_log.size()); end
  endtask

  initial begin
    reset      = 1'b1;
    msg_valid  = 1'b0;
    msg_data   = '0;
    msg_last   = 1'b0;
    msg_bytes  = '0;
    hash_ready = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_55_56();
    test_full_block();
    test_random_gaps();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
